pc_fetch_unit: RTL and testbench



---
 rtl/rv32i_pkg.sv | 17 +
 rtl/pc_fetch_unit_if.sv | 28 ++
 rtl/fetch_queue.sv | 58 +++++
 rtl/pc_fetch_unit.sv | 129 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: fetch FSM states, word size and PC step helper.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FAULT
    } fetch_state_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + INSN_BYTES;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch front-end bundle: redirect inputs, imem request/response and decode delivery channels.
interface pc_fetch_unit_if;
    import rv32i_pkg::*;

    logic            pc_src;
    logic [XLEN-1:0] pc_addr;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            fetch_fault;

    modport master (
        input  pc_src, pc_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault
    );

    modport slave (
        output pc_src, pc_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, inst} entries; flush has priority over push and pop.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// RV32I PC and instruction-fetch front end: credit-limited in-order fetch, 2-entry queue,
// redirect flush with in-flight drop counting, sticky misaligned-redirect fault.
module pc_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input logic              clk,
    input logic              rst_n,
    pc_fetch_unit_if.master  bus
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] fetch_pc, fetch_pc_n;
    logic [XLEN-1:0] resp_pc, resp_pc_n;
    logic [CW-1:0]   outstanding, outstanding_n;
    logic [CW-1:0]   drop_cnt, drop_cnt_n;
    logic [CW-1:0]   out_after;
    logic [CW:0]     in_use;

    logic              q_flush, q_push, q_pop;
    logic              q_full, q_empty;
    logic [CW-1:0]     q_count;
    logic [2*XLEN-1:0] q_push_data, q_head;

    logic req_valid, req_fire, rsp, inst_fire;
    logic redirect_ok, misalign;

    fetch_queue #(
        .DEPTH (QDEPTH),
        .W     (2 * XLEN)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (q_flush),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Credit covers both in-flight requests and queued words, so responses never overflow.
    assign in_use    = {1'b0, outstanding} + {1'b0, q_count};
    assign req_valid = rst_n && (state == RUN) && !q_full && (in_use < (CW + 1)'(QDEPTH));

    assign req_fire    = req_valid & bus.imem_req_ready;
    assign rsp         = bus.imem_rsp_valid;
    assign inst_fire   = bus.inst_valid & bus.inst_ready;
    assign redirect_ok = bus.pc_src & (bus.pc_addr[1:0] == 2'b00);
    assign misalign    = bus.pc_src & (bus.pc_addr[1:0] != 2'b00);
    assign out_after   = outstanding + CW'(req_fire) - CW'(rsp);
    assign q_push_data = {resp_pc, bus.imem_rsp_data};

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = (state == RUN) && !q_empty;
    assign bus.inst_data      = q_head[XLEN-1:0];
    assign bus.inst_pc        = q_head[2*XLEN-1:XLEN];
    assign bus.fetch_fault    = (state == FAULT);

    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        resp_pc_n     = resp_pc;
        outstanding_n = out_after;
        drop_cnt_n    = drop_cnt;
        q_flush       = 1'b0;
        q_push        = 1'b0;
        q_pop         = inst_fire;
        case (state)
            RUN: begin
                if (req_fire) fetch_pc_n = next_pc(fetch_pc);
                if (rsp) begin
                    q_push    = 1'b1;
                    resp_pc_n = next_pc(resp_pc);
                end
                if (redirect_ok) begin
                    fetch_pc_n = bus.pc_addr;
                    resp_pc_n  = bus.pc_addr;
                    q_flush    = 1'b1;
                    drop_cnt_n = out_after;
                    if (out_after != '0) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (rsp) drop_cnt_n = drop_cnt - CW'(1);
                if (redirect_ok) begin
                    fetch_pc_n = bus.pc_addr;
                    resp_pc_n  = bus.pc_addr;
                end
                if (drop_cnt_n == '0) state_n = RUN;
            end
            FAULT: begin
                state_n = FAULT;
            end
            default: begin
                state_n = RUN;
            end
        endcase
        // A misaligned target overrides everything and parks the unit until reset.
        if (misalign) begin
            state_n = FAULT;
            q_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            resp_pc     <= resp_pc_n;
            outstanding <= outstanding_n;
            drop_cnt    <= drop_cnt_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: memory model with configurable latency, directed scenarios.
module tb_pc_fetch_unit;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0100),
        .QDEPTH   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;
    int n_deliv = 0;
    int exp_rd = 0;
    int exp_lo = 0;
    int log_base = 0;
    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] req_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Instruction memory: accepts every request, answers in order after lat cycles.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) pend.delete();
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend[0].addr);
                pend.delete(0);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
            @(negedge clk);
            if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
                pend.push_back('{bus.imem_req_addr, cyc + lat});
                req_log.push_back(bus.imem_req_addr);
            end
        end
    end

    // Monitor: every delivered instruction is checked against the next expected PC.
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (exp_rd < exp_lo) exp_rd = exp_lo;
            if (rst_n && bus.inst_valid && bus.inst_ready) begin
                n_deliv++;
                if (exp_rd < exp_q.size()) begin
                    e = exp_q[exp_rd];
                    exp_rd++;
                    check("inst_pc", bus.inst_pc, e);
                    check("inst_data", bus.inst_data, mem_word(e));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_stream(input logic [31:0] start, input int n);
        exp_lo = exp_q.size();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    function automatic int pending();
        return exp_q.size() - ((exp_rd > exp_lo) ? exp_rd : exp_lo);
    endfunction

    task automatic wait_exp_empty(input string name, input int budget);
        int n;
        n = 0;
        while (pending() > 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, pending(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_req_valid", bus.imem_req_valid, 1'b0);
        check("rst_inst_valid", bus.inst_valid, 1'b0);
        check("rst_fault", bus.fetch_fault, 1'b0);
        tick(2);
        rst_n = 1'b1;
        log_base = req_log.size();
    endtask

    task automatic redirect(input logic [31:0] addr);
        bus.pc_src  = 1'b1;
        bus.pc_addr = addr;
        tick(1);
        bus.pc_src  = 1'b0;
        log_base = req_log.size();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bus.pc_src         = 1'b0;
        bus.pc_addr        = '0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b0;
        tick(1);

        // Reset and streaming, 1-cycle memory
        lat = 1;
        do_reset();
        expect_stream(32'h100, 8);
        @(negedge clk);
        check("first_req_valid", bus.imem_req_valid, 1'b1);
        check("first_req_addr", bus.imem_req_addr, 32'h100);
        tick(1);
        bus.inst_ready = 1'b1;
        wait_exp_empty("stream_done", 40);
        bus.inst_ready = 1'b0;

        // Backpressure: only two fetches while decode stalls
        do_reset();
        expect_stream(32'h100, 4);
        tick(10);
        check("bp_req_count", req_log.size() - log_base, 2);
        check("bp_req0", req_log[log_base], 32'h100);
        check("bp_req1", req_log[log_base + 1], 32'h104);
        @(negedge clk);
        check("bp_head_valid", bus.inst_valid, 1'b1);
        check("bp_head_pc", bus.inst_pc, 32'h100);
        tick(1);
        bus.inst_ready = 1'b1;
        wait_exp_empty("bp_done", 40);
        bus.inst_ready = 1'b0;

        // Redirect with two fetches in flight, 3-cycle memory
        lat = 3;
        do_reset();
        tick(2);
        expect_stream(32'h400, 4);
        bus.inst_ready = 1'b1;
        redirect(32'h400);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("drain_req_valid", bus.imem_req_valid, 1'b0);
            check("drain_inst_valid", bus.inst_valid, 1'b0);
        end
        @(negedge clk);
        check("resume_req_valid", bus.imem_req_valid, 1'b1);
        check("resume_req_addr", bus.imem_req_addr, 32'h400);
        tick(1);
        wait_exp_empty("redir_done", 60);
        check("redir_first_req", req_log[log_base], 32'h400);
        bus.inst_ready = 1'b0;

        // Back-to-back redirects while draining
        do_reset();
        tick(2);
        expect_stream(32'h300, 4);
        bus.inst_ready = 1'b1;
        redirect(32'h200);
        redirect(32'h300);
        wait_exp_empty("b2b_done", 60);
        check("b2b_first_req", req_log[log_base], 32'h300);
        bus.inst_ready = 1'b0;
        tick(12);
        check("b2b_outstanding", 32'(dut.outstanding), 0);

        // Misaligned redirect parks the unit until reset
        redirect(32'h202);
        @(negedge clk);
        check("fault_set", bus.fetch_fault, 1'b1);
        check("fault_req_valid", bus.imem_req_valid, 1'b0);
        check("fault_inst_valid", bus.inst_valid, 1'b0);
        tick(1);
        d0 = n_deliv;
        bus.inst_ready = 1'b1;
        tick(6);
        check("fault_sticky", bus.fetch_fault, 1'b1);
        check("fault_no_req", req_log.size() - log_base, 0);
        check("fault_no_inst", n_deliv - d0, 0);
        bus.inst_ready = 1'b0;
        do_reset();
        expect_stream(32'h100, 3);
        @(negedge clk);
        check("post_fault_req_addr", bus.imem_req_addr, 32'h100);
        check("post_fault_clear", bus.fetch_fault, 1'b0);
        tick(1);
        bus.inst_ready = 1'b1;
        wait_exp_empty("post_fault_done", 60);
        bus.inst_ready = 1'b0;

        // Wrap-around redirect with nothing outstanding
        lat = 1;
        do_reset();
        tick(8);
        expect_stream(32'hFFFF_FFFC, 4);
        redirect(32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_req_valid", bus.imem_req_valid, 1'b1);
        check("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        check("wrap_inst_valid", bus.inst_valid, 1'b0);
        tick(1);
        bus.inst_ready = 1'b1;
        wait_exp_empty("wrap_done", 40);
        check("wrap_req0", req_log[log_base], 32'hFFFF_FFFC);
        check("wrap_req1", req_log[log_base + 1], 32'h0000_0000);
        bus.inst_ready = 1'b0;

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
